// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue bundle between the ALU reservation station and its neighbours.
interface alu_rs_if #(
    parameter int unsigned Q_WIDTH = 5
) ();
    localparam int unsigned OP_W = 10;
    localparam int unsigned XLEN = 32;

    // dispatch
    logic               in_valid;
    logic [OP_W-1:0]    in_op;
    logic [XLEN-1:0]    in_v1;
    logic [XLEN-1:0]    in_v2;
    logic [Q_WIDTH-1:0] in_q1;
    logic [Q_WIDTH-1:0] in_q2;
    logic [XLEN-1:0]    in_imm;
    logic [XLEN-1:0]    in_npc;
    logic [Q_WIDTH-1:0] in_dest;
    logic               full;

    // common data buses (ALU, LSB)
    logic               cdb0_valid;
    logic [Q_WIDTH-1:0] cdb0_tag;
    logic [XLEN-1:0]    cdb0_value;
    logic               cdb1_valid;
    logic [Q_WIDTH-1:0] cdb1_tag;
    logic [XLEN-1:0]    cdb1_value;

    // issue slot to EX
    logic               issue_valid;
    logic [OP_W-1:0]    issue_op;
    logic [XLEN-1:0]    issue_v1;
    logic [XLEN-1:0]    issue_v2;
    logic [XLEN-1:0]    issue_imm;
    logic [XLEN-1:0]    issue_npc;
    logic [Q_WIDTH-1:0] issue_dest;

    modport master (
        output in_valid, in_op, in_v1, in_v2, in_q1, in_q2, in_imm, in_npc, in_dest,
        output cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
        input  full,
        input  issue_valid, issue_op, issue_v1, issue_v2, issue_imm, issue_npc, issue_dest
    );

    modport slave (
        input  in_valid, in_op, in_v1, in_v2, in_q1, in_q2, in_imm, in_npc, in_dest,
        input  cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
        output full,
        output issue_valid, issue_op, issue_v1, issue_v2, issue_imm, issue_npc, issue_dest
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops until both operands are
// resolved (directly or via CDB wakeup) and issues one ready entry per cycle.
module alu_reservation_station #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned Q_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy_i,
    input  logic     clear_i,
    alu_rs_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned OP_W  = 10;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic               busy;
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    v1;
        logic [XLEN-1:0]    v2;
        logic [Q_WIDTH-1:0] q1;
        logic [Q_WIDTH-1:0] q2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    npc;
        logic [Q_WIDTH-1:0] dest;
    } entry_t;

    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    v1;
        logic [XLEN-1:0]    v2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    npc;
        logic [Q_WIDTH-1:0] dest;
    } issue_t;

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    issue_t             iss_q;
    issue_t             iss_d;

    logic               full_c;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;

    // A pending tag (non-zero) is satisfied by a valid broadcast carrying the same tag.
    function automatic logic tag_hit(input logic [Q_WIDTH-1:0] q,
                                     input logic               cdb_valid,
                                     input logic [Q_WIDTH-1:0] cdb_tag);
        return cdb_valid && (q != '0) && (q == cdb_tag);
    endfunction

    // Occupancy, lowest free slot and lowest ready slot, all from registered state.
    always_comb begin
        full_c     = 1'b1;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!ent_q[i].busy) begin
                full_c = 1'b0;
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end
            if (ent_q[i].busy && (ent_q[i].q1 == '0) && (ent_q[i].q2 == '0) && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Next state: flush, or wakeup + issue + insert (insert slot is never the issuing slot).
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ent_d[i] = ent_q[i];
        end
        iss_d = '0;

        if (clear_i) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_d[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (ent_q[i].busy) begin
                    if (tag_hit(ent_q[i].q1, bus.cdb0_valid, bus.cdb0_tag)) begin
                        ent_d[i].v1 = bus.cdb0_value;
                        ent_d[i].q1 = '0;
                    end else if (tag_hit(ent_q[i].q1, bus.cdb1_valid, bus.cdb1_tag)) begin
                        ent_d[i].v1 = bus.cdb1_value;
                        ent_d[i].q1 = '0;
                    end
                    if (tag_hit(ent_q[i].q2, bus.cdb0_valid, bus.cdb0_tag)) begin
                        ent_d[i].v2 = bus.cdb0_value;
                        ent_d[i].q2 = '0;
                    end else if (tag_hit(ent_q[i].q2, bus.cdb1_valid, bus.cdb1_tag)) begin
                        ent_d[i].v2 = bus.cdb1_value;
                        ent_d[i].q2 = '0;
                    end
                end
            end

            if (sel_found) begin
                iss_d.valid         = 1'b1;
                iss_d.op            = ent_q[sel_idx].op;
                iss_d.v1            = ent_q[sel_idx].v1;
                iss_d.v2            = ent_q[sel_idx].v2;
                iss_d.imm           = ent_q[sel_idx].imm;
                iss_d.npc           = ent_q[sel_idx].npc;
                iss_d.dest          = ent_q[sel_idx].dest;
                ent_d[sel_idx].busy = 1'b0;
            end

            if (bus.in_valid && !full_c) begin
                ent_d[free_idx].busy = 1'b1;
                ent_d[free_idx].op   = bus.in_op;
                ent_d[free_idx].imm  = bus.in_imm;
                ent_d[free_idx].npc  = bus.in_npc;
                ent_d[free_idx].dest = bus.in_dest;
                ent_d[free_idx].v1   = bus.in_v1;
                ent_d[free_idx].q1   = bus.in_q1;
                ent_d[free_idx].v2   = bus.in_v2;
                ent_d[free_idx].q2   = bus.in_q2;
                if (tag_hit(bus.in_q1, bus.cdb0_valid, bus.cdb0_tag)) begin
                    ent_d[free_idx].v1 = bus.cdb0_value;
                    ent_d[free_idx].q1 = '0;
                end else if (tag_hit(bus.in_q1, bus.cdb1_valid, bus.cdb1_tag)) begin
                    ent_d[free_idx].v1 = bus.cdb1_value;
                    ent_d[free_idx].q1 = '0;
                end
                if (tag_hit(bus.in_q2, bus.cdb0_valid, bus.cdb0_tag)) begin
                    ent_d[free_idx].v2 = bus.cdb0_value;
                    ent_d[free_idx].q2 = '0;
                end else if (tag_hit(bus.in_q2, bus.cdb1_valid, bus.cdb1_tag)) begin
                    ent_d[free_idx].v2 = bus.cdb1_value;
                    ent_d[free_idx].q2 = '0;
                end
            end
        end
    end

    // State registers; rdy low freezes everything including the issue slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_q[i] <= '0;
            end
            iss_q <= '0;
        end else if (rdy_i) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_q[i] <= ent_d[i];
            end
            iss_q <= iss_d;
        end
    end

    assign bus.full        = full_c;
    assign bus.issue_valid = iss_q.valid;
    assign bus.issue_op    = iss_q.op;
    assign bus.issue_v1    = iss_q.v1;
    assign bus.issue_v2    = iss_q.v2;
    assign bus.issue_imm   = iss_q.imm;
    assign bus.issue_npc   = iss_q.npc;
    assign bus.issue_dest  = iss_q.dest;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: per-cycle comparison against a behavioural
// model of the buffer, plus directed scenarios with literal expectations.
module tb_alu_reservation_station;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    logic rdy;
    logic clear;

    int n_cmp;
    int n_bad;

    alu_rs_if #(.Q_WIDTH(5)) bus ();

    alu_reservation_station #(.RS_SIZE(8), .Q_WIDTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy_i   (rdy),
        .clear_i (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_busy [N];
    logic [9:0]  m_op   [N];
    logic [31:0] m_v1   [N];
    logic [31:0] m_v2   [N];
    logic [4:0]  m_q1   [N];
    logic [4:0]  m_q2   [N];
    logic [31:0] m_imm  [N];
    logic [31:0] m_npc  [N];
    logic [4:0]  m_dest [N];
    logic        m_iv;
    logic [9:0]  m_iop;
    logic [31:0] m_iv1, m_iv2, m_iimm, m_inpc;
    logic [4:0]  m_idest;

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) if (m_busy[k]) c++;
        return c;
    endfunction

    function automatic int m_first_ready();
        for (int k = 0; k < N; k++)
            if (m_busy[k] && m_q1[k] == 5'd0 && m_q2[k] == 5'd0) return k;
        return -1;
    endfunction

    function automatic int m_first_free();
        for (int k = 0; k < N; k++) if (!m_busy[k]) return k;
        return -1;
    endfunction

    // operand after this cycle's broadcasts: {tag, value}
    function automatic logic [36:0] resolve(input logic [4:0] q, input logic [31:0] v);
        if (q != 5'd0 && bus.cdb0_valid && bus.cdb0_tag == q) return {5'd0, bus.cdb0_value};
        if (q != 5'd0 && bus.cdb1_valid && bus.cdb1_tag == q) return {5'd0, bus.cdb1_value};
        return {q, v};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_busy[k] <= 1'b0;
            m_iv <= 1'b0; m_iop <= '0; m_iv1 <= '0; m_iv2 <= '0;
            m_iimm <= '0; m_inpc <= '0; m_idest <= '0;
        end else if (rdy) begin
            if (clear) begin
                for (int k = 0; k < N; k++) m_busy[k] <= 1'b0;
                m_iv <= 1'b0; m_iop <= '0; m_iv1 <= '0; m_iv2 <= '0;
                m_iimm <= '0; m_inpc <= '0; m_idest <= '0;
            end else begin : normal
                int r;
                int f;
                r = m_first_ready();
                f = m_first_free();
                for (int k = 0; k < N; k++) begin
                    if (m_busy[k]) begin
                        {m_q1[k], m_v1[k]} <= resolve(m_q1[k], m_v1[k]);
                        {m_q2[k], m_v2[k]} <= resolve(m_q2[k], m_v2[k]);
                    end
                end
                if (r >= 0) begin
                    m_iv <= 1'b1; m_iop <= m_op[r]; m_iv1 <= m_v1[r]; m_iv2 <= m_v2[r];
                    m_iimm <= m_imm[r]; m_inpc <= m_npc[r]; m_idest <= m_dest[r];
                    m_busy[r] <= 1'b0;
                end else begin
                    m_iv <= 1'b0; m_iop <= '0; m_iv1 <= '0; m_iv2 <= '0;
                    m_iimm <= '0; m_inpc <= '0; m_idest <= '0;
                end
                if (bus.in_valid && m_count() != N) begin
                    m_busy[f] <= 1'b1;
                    m_op[f]   <= bus.in_op;
                    m_imm[f]  <= bus.in_imm;
                    m_npc[f]  <= bus.in_npc;
                    m_dest[f] <= bus.in_dest;
                    {m_q1[f], m_v1[f]} <= resolve(bus.in_q1, bus.in_v1);
                    {m_q2[f], m_v2[f]} <= resolve(bus.in_q2, bus.in_v2);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        n_cmp++;
        if (bus.full !== (m_count() == N)) begin
            n_bad++;
            $display("FAIL full @%0t: dut=%0b model=%0b", $time, bus.full, (m_count() == N));
        end
        n_cmp++;
        if ({bus.issue_valid, bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_imm,
             bus.issue_npc, bus.issue_dest} !==
            {m_iv, m_iop, m_iv1, m_iv2, m_iimm, m_inpc, m_idest}) begin
            n_bad++;
            $display("FAIL issue @%0t: dut=%h model=%h", $time,
                     {bus.issue_valid, bus.issue_op, bus.issue_v1, bus.issue_v2, bus.issue_imm,
                      bus.issue_npc, bus.issue_dest},
                     {m_iv, m_iop, m_iv1, m_iv2, m_iimm, m_inpc, m_idest});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.cdb0_valid = 1'b0;
        bus.cdb1_valid = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic disp(input logic [9:0] op, input logic [31:0] v1, input logic [4:0] q1,
                        input logic [31:0] v2, input logic [4:0] q2, input logic [4:0] dest);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_v1    = v1;
        bus.in_q1    = q1;
        bus.in_v2    = v2;
        bus.in_q2    = q2;
        bus.in_dest  = dest;
        bus.in_imm   = 32'h100 + 32'(dest);
        bus.in_npc   = 32'h1000 + 32'(dest) * 32'd4;
    endtask

    task automatic cdb(input int port, input logic [4:0] tag, input logic [31:0] value);
        if (port == 0) begin
            bus.cdb0_valid = 1'b1; bus.cdb0_tag = tag; bus.cdb0_value = value;
        end else begin
            bus.cdb1_valid = 1'b1; bus.cdb1_tag = tag; bus.cdb1_value = value;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        rdy   = 1'b1;
        bus.in_op = '0; bus.in_v1 = '0; bus.in_v2 = '0; bus.in_q1 = '0; bus.in_q2 = '0;
        bus.in_imm = '0; bus.in_npc = '0; bus.in_dest = '0;
        bus.cdb0_tag = '0; bus.cdb0_value = '0; bus.cdb1_tag = '0; bus.cdb1_value = '0;
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_valid", 32'(bus.issue_valid), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // simple ready insert: issues one edge after becoming resident
        disp(10'h001, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        step();
        idle();
        chk("add_not_yet", 32'(bus.issue_valid), 32'd0);
        step();
        chk("add_valid", 32'(bus.issue_valid), 32'd1);
        chk("add_v1", bus.issue_v1, 32'd5);
        chk("add_v2", bus.issue_v2, 32'd7);
        chk("add_dest", 32'(bus.issue_dest), 32'd3);
        chk("add_npc", bus.issue_npc, 32'h100c);
        step();
        chk("add_one_cycle", 32'(bus.issue_valid), 32'd0);

        // wakeup via cdb1 two cycles after insert
        disp(10'h002, 32'd0, 5'd4, 32'd2, 5'd0, 5'd5);
        step();
        idle();
        step();
        cdb(1, 5'd4, 32'h10);
        step();
        idle();
        chk("wake_not_yet", 32'(bus.issue_valid), 32'd0);
        step();
        chk("wake_valid", 32'(bus.issue_valid), 32'd1);
        chk("wake_v1", bus.issue_v1, 32'h10);
        chk("wake_dest", 32'(bus.issue_dest), 32'd5);

        // insert bypass from cdb0 in the same cycle
        disp(10'h003, 32'd0, 5'd4, 32'd9, 5'd0, 5'd6);
        cdb(0, 5'd4, 32'h22);
        step();
        idle();
        chk("byp_not_yet", 32'(bus.issue_valid), 32'd0);
        step();
        chk("byp_valid", 32'(bus.issue_valid), 32'd1);
        chk("byp_v1", bus.issue_v1, 32'h22);
        chk("byp_dest", 32'(bus.issue_dest), 32'd6);
        step();

        // fill all entries waiting on tag 9, overflow insert ignored
        for (int i = 0; i < N; i++) begin
            disp(10'h004, 32'd0, 5'd9, 32'(i), 5'd0, 5'(i + 1));
            step();
        end
        idle();
        chk("fill_full", 32'(bus.full), 32'd1);
        disp(10'h005, 32'd1, 5'd0, 32'd1, 5'd0, 5'd20);
        step();
        idle();
        chk("overflow_full", 32'(bus.full), 32'd1);
        chk("overflow_no_issue", 32'(bus.issue_valid), 32'd0);
        cdb(0, 5'd9, 32'h99);
        step();
        idle();
        chk("fill_woken_not_issued", 32'(bus.issue_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("drain_valid", 32'(bus.issue_valid), 32'd1);
            chk("drain_dest", 32'(bus.issue_dest), 32'(i + 1));
            chk("drain_v1", bus.issue_v1, 32'h99);
            if (i == 0) chk("drain_full_drop", 32'(bus.full), 32'd0);
        end
        step();
        chk("drain_done", 32'(bus.issue_valid), 32'd0);

        // clear with busy entries and concurrent insert/broadcast
        for (int i = 0; i < 5; i++) begin
            disp(10'h006, 32'd0, 5'd7, 32'd0, 5'd0, 5'(21 + i));
            step();
        end
        idle();
        clear = 1'b1;
        disp(10'h007, 32'd1, 5'd0, 32'd2, 5'd0, 5'd30);
        cdb(0, 5'd7, 32'h77);
        step();
        idle();
        chk("clear_full", 32'(bus.full), 32'd0);
        chk("clear_valid", 32'(bus.issue_valid), 32'd0);
        cdb(0, 5'd7, 32'h77);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clear_no_issue", 32'(bus.issue_valid), 32'd0);
        end

        // rdy low freezes issue slot and defers broadcast/insert
        disp(10'h008, 32'hA, 5'd0, 32'd1, 5'd0, 5'd12);
        step();
        disp(10'h009, 32'd0, 5'd11, 32'd3, 5'd0, 5'd13);
        step();
        idle();
        chk("frz_pre_valid", 32'(bus.issue_valid), 32'd1);
        chk("frz_pre_dest", 32'(bus.issue_dest), 32'd12);
        rdy = 1'b0;
        cdb(1, 5'd11, 32'h55);
        disp(10'h00a, 32'd4, 5'd0, 32'd5, 5'd0, 5'd14);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_valid", 32'(bus.issue_valid), 32'd1);
            chk("frz_dest", 32'(bus.issue_dest), 32'd12);
        end
        rdy = 1'b1;
        step();
        idle();
        chk("resume_gap", 32'(bus.issue_valid), 32'd0);
        step();
        chk("resume_first_dest", 32'(bus.issue_dest), 32'd14);
        step();
        chk("resume_second_dest", 32'(bus.issue_dest), 32'd13);
        chk("resume_second_v1", bus.issue_v1, 32'h55);
        step();
        chk("resume_done", 32'(bus.issue_valid), 32'd0);

        // asynchronous reset mid-run with three waiting entries and a live issue
        for (int i = 0; i < 3; i++) begin
            disp(10'h00b, 32'd0, 5'd15, 32'd0, 5'd0, 5'(24 + i));
            step();
        end
        disp(10'h00c, 32'd6, 5'd0, 32'd6, 5'd0, 5'd27);
        step();
        idle();
        step();
        chk("pre_rst_valid", 32'(bus.issue_valid), 32'd1);
        chk("pre_rst_dest", 32'(bus.issue_dest), 32'd27);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_full", 32'(bus.full), 32'd0);
        chk("async_rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("async_rst_dest", 32'(bus.issue_dest), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cdb(0, 5'd15, 32'hF);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_stale", 32'(bus.issue_valid), 32'd0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
